// File: rtl/bq_pwrmon_pkg.sv
// Shared types and width helpers for the windowed power monitor.
package bq_pwrmon_pkg;

   typedef enum logic [1:0] {IDLE, FILL, ACCUM} state_t;

   localparam int unsigned FILL_LEN = 3;

   function automatic int unsigned acc_bits(input int unsigned nsamp, input int unsigned nbits,
                                            input int unsigned wlog2);
      return 2*nbits - 1 + $clog2(nsamp) + wlog2;
   endfunction

   function automatic int unsigned cnt_bits(input int unsigned nsamp, input int unsigned wlog2);
      return $clog2(nsamp) + wlog2 + 1;
   endfunction

   function automatic int unsigned sum_bits(input int unsigned nsamp, input int unsigned nbits);
      return 2*nbits - 1 + $clog2(nsamp);
   endfunction

   function automatic int unsigned pop_bits(input int unsigned nsamp);
      return $clog2(nsamp) + 1;
   endfunction

endpackage

// File: rtl/bq_power_monitor_if.sv
// Sample bus in, per-window power/over/peak results out.
interface bq_power_monitor_if
   import bq_pwrmon_pkg::*;
#(
   parameter int unsigned NSAMP       = 8,
   parameter int unsigned NBITS       = 12,
   parameter int unsigned WINDOW_LOG2 = 10
);
   localparam int unsigned ACCBITS = acc_bits(NSAMP, NBITS, WINDOW_LOG2);
   localparam int unsigned CNTBITS = cnt_bits(NSAMP, WINDOW_LOG2);

   logic [NBITS*NSAMP-1:0] dat_i;
   logic                   run_i;
   logic [NBITS-1:0]       thresh_i;
   logic [ACCBITS-1:0]     power_o;
   logic [CNTBITS-1:0]     over_o;
   logic [NBITS-1:0]       peak_o;
   logic                   done_o;

   modport master (output dat_i, run_i, thresh_i, input power_o, over_o, peak_o, done_o);
   modport slave  (input dat_i, run_i, thresh_i, output power_o, over_o, peak_o, done_o);

endinterface

// File: rtl/bq_pwrmon_sq_tree.sv
// Three-stage front end: |x| and threshold flags, squares/popcount/max, sum of squares.
// Peak path exists only when BQ_PWRMON_PEAK_EN is defined.
module bq_pwrmon_sq_tree
   import bq_pwrmon_pkg::*;
#(
   parameter int unsigned NSAMP = 8,
   parameter int unsigned NBITS = 12
) (
   input  logic                                 aclk,
   input  logic                                 rst_i,
   input  logic [NBITS*NSAMP-1:0]               dat_i,
   input  logic [NBITS-1:0]                     thresh_i,
   output logic [sum_bits(NSAMP, NBITS)-1:0]    sum_o,
   output logic [pop_bits(NSAMP)-1:0]           over_o
`ifdef BQ_PWRMON_PEAK_EN
   ,output logic [NBITS-1:0]                    peak_o
`endif
);

   localparam int unsigned PW   = 2*NBITS;
   localparam int unsigned SQW  = 2*NBITS - 1;
   localparam int unsigned SUMW = sum_bits(NSAMP, NBITS);
   localparam int unsigned POPW = pop_bits(NSAMP);

   logic [NBITS-1:0] mag_d [NSAMP];
   logic [NBITS-1:0] mag_q [NSAMP];
   logic [NSAMP-1:0] flag_d, flag_q;
   logic [SQW-1:0]   sq_d  [NSAMP];
   logic [SQW-1:0]   sq_q  [NSAMP];
   logic [POPW-1:0]  pop_d, pop_q, pop2_q;
   logic [SUMW-1:0]  sum_d, sum_q;
`ifdef BQ_PWRMON_PEAK_EN
   logic [NBITS-1:0] pk_d, pk_q, pk2_q;
`endif

   // Negating -2^(NBITS-1) wraps to the same bit pattern, which reads as 2^(NBITS-1) unsigned.
   always_comb begin
      for (int unsigned i = 0; i < NSAMP; i++) begin
         mag_d[i]  = dat_i[NBITS*i + NBITS - 1] ? -dat_i[NBITS*i +: NBITS] : dat_i[NBITS*i +: NBITS];
         flag_d[i] = mag_d[i] > thresh_i;
      end
   end

   always_comb begin
      pop_d = '0;
`ifdef BQ_PWRMON_PEAK_EN
      pk_d  = '0;
`endif
      for (int unsigned i = 0; i < NSAMP; i++) begin
         sq_d[i] = SQW'(PW'(mag_q[i]) * PW'(mag_q[i]));
         pop_d   = pop_d + POPW'(flag_q[i]);
`ifdef BQ_PWRMON_PEAK_EN
         if (mag_q[i] > pk_d) pk_d = mag_q[i];
`endif
      end
   end

   always_comb begin
      sum_d = '0;
      for (int unsigned i = 0; i < NSAMP; i++) begin
         sum_d = sum_d + SUMW'(sq_q[i]);
      end
   end

   always_ff @(posedge aclk) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < NSAMP; i++) begin
            mag_q[i] <= '0;
            sq_q[i]  <= '0;
         end
         flag_q <= '0;
         pop_q  <= '0;
         pop2_q <= '0;
         sum_q  <= '0;
`ifdef BQ_PWRMON_PEAK_EN
         pk_q   <= '0;
         pk2_q  <= '0;
`endif
      end else begin
         for (int unsigned i = 0; i < NSAMP; i++) begin
            mag_q[i] <= mag_d[i];
            sq_q[i]  <= sq_d[i];
         end
         flag_q <= flag_d;
         pop_q  <= pop_d;
         pop2_q <= pop_q;
         sum_q  <= sum_d;
`ifdef BQ_PWRMON_PEAK_EN
         pk_q   <= pk_d;
         pk2_q  <= pk_q;
`endif
      end
   end

   assign sum_o  = sum_q;
   assign over_o = pop2_q;
`ifdef BQ_PWRMON_PEAK_EN
   assign peak_o = pk2_q;
`endif

endmodule

// File: rtl/bq_power_monitor.sv
// Windowed power monitor top: FSM, window counter, accumulators, result registers.
// Define BQ_PWRMON_PEAK_EN to build peak tracking; otherwise peak_o is tied to 0.
module bq_power_monitor
   import bq_pwrmon_pkg::*;
#(
   parameter int unsigned NSAMP       = 8,
   parameter int unsigned NBITS       = 12,
   parameter int unsigned WINDOW_LOG2 = 10
) (
   input  logic                aclk,
   input  logic                rst_i,
   bq_power_monitor_if.slave   bus
);

   localparam int unsigned ACCBITS = acc_bits(NSAMP, NBITS, WINDOW_LOG2);
   localparam int unsigned CNTBITS = cnt_bits(NSAMP, WINDOW_LOG2);
   localparam int unsigned SUMW    = sum_bits(NSAMP, NBITS);
   localparam int unsigned POPW    = pop_bits(NSAMP);
   localparam int unsigned FCW     = $clog2(FILL_LEN);

   state_t                 state_q, state_d;
   logic [FCW-1:0]         fcnt_q, fcnt_d;
   logic [WINDOW_LOG2-1:0] wcnt_q, wcnt_d;
   logic [ACCBITS-1:0]     pacc_q, pacc_d, power_q, power_d;
   logic [CNTBITS-1:0]     oacc_q, oacc_d, over_q, over_d;
   logic                   done_q, done_d;
   logic [SUMW-1:0]        tree_sum;
   logic [POPW-1:0]        tree_over;
`ifdef BQ_PWRMON_PEAK_EN
   logic [NBITS-1:0]       kacc_q, kacc_d, peak_q, peak_d, tree_peak;
`endif

   bq_pwrmon_sq_tree #(
      .NSAMP (NSAMP),
      .NBITS (NBITS)
   ) u_sq_tree (
      .aclk     (aclk),
      .rst_i    (rst_i),
      .dat_i    (bus.dat_i),
      .thresh_i (bus.thresh_i),
      .sum_o    (tree_sum),
      .over_o   (tree_over)
`ifdef BQ_PWRMON_PEAK_EN
      ,.peak_o  (tree_peak)
`endif
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.run_i) state_d = FILL;
         FILL:    if (!bus.run_i) state_d = IDLE;
                  else if (fcnt_q == FCW'(FILL_LEN - 1)) state_d = ACCUM;
         ACCUM:   if (!bus.run_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Leaving FILL loads the first sample exactly like a window wrap, so every window
   // starts with a reload and the terminal count only ever sees complete windows.
   always_comb begin
      fcnt_d  = fcnt_q;
      wcnt_d  = wcnt_q;
      pacc_d  = pacc_q;
      oacc_d  = oacc_q;
      power_d = power_q;
      over_d  = over_q;
      done_d  = 1'b0;
`ifdef BQ_PWRMON_PEAK_EN
      kacc_d  = kacc_q;
      peak_d  = peak_q;
`endif
      case (state_q)
         IDLE: fcnt_d = '0;
         FILL: begin
            fcnt_d = fcnt_q + FCW'(1);
            if (state_d == ACCUM) begin
               pacc_d = ACCBITS'(tree_sum);
               oacc_d = CNTBITS'(tree_over);
               wcnt_d = '0;
`ifdef BQ_PWRMON_PEAK_EN
               kacc_d = tree_peak;
`endif
            end
         end
         ACCUM: begin
            if (state_d == ACCUM) begin
               if (wcnt_q == '1) begin
                  power_d = pacc_q;
                  over_d  = oacc_q;
                  done_d  = 1'b1;
                  pacc_d  = ACCBITS'(tree_sum);
                  oacc_d  = CNTBITS'(tree_over);
                  wcnt_d  = '0;
`ifdef BQ_PWRMON_PEAK_EN
                  peak_d  = kacc_q;
                  kacc_d  = tree_peak;
`endif
               end else begin
                  pacc_d  = pacc_q + ACCBITS'(tree_sum);
                  oacc_d  = oacc_q + CNTBITS'(tree_over);
                  wcnt_d  = wcnt_q + WINDOW_LOG2'(1);
`ifdef BQ_PWRMON_PEAK_EN
                  if (tree_peak > kacc_q) kacc_d = tree_peak;
`endif
               end
            end
         end
         default: ;
      endcase
      if (state_d == IDLE) begin
         fcnt_d = '0;
         wcnt_d = '0;
         pacc_d = '0;
         oacc_d = '0;
`ifdef BQ_PWRMON_PEAK_EN
         kacc_d = '0;
`endif
      end
   end

   always_ff @(posedge aclk) begin
      if (rst_i) begin
         state_q <= IDLE;
         fcnt_q  <= '0;
         wcnt_q  <= '0;
         pacc_q  <= '0;
         oacc_q  <= '0;
         power_q <= '0;
         over_q  <= '0;
         done_q  <= 1'b0;
`ifdef BQ_PWRMON_PEAK_EN
         kacc_q  <= '0;
         peak_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         wcnt_q  <= wcnt_d;
         pacc_q  <= pacc_d;
         oacc_q  <= oacc_d;
         power_q <= power_d;
         over_q  <= over_d;
         done_q  <= done_d;
`ifdef BQ_PWRMON_PEAK_EN
         kacc_q  <= kacc_d;
         peak_q  <= peak_d;
`endif
      end
   end

   assign bus.power_o = power_q;
   assign bus.over_o  = over_q;
   assign bus.done_o  = done_q;
`ifdef BQ_PWRMON_PEAK_EN
   assign bus.peak_o  = peak_q;
`else
   assign bus.peak_o  = '0;
`endif

endmodule

// File: tb/tb_bq_power_monitor.sv
// Bench for bq_power_monitor (W=16): directed scenarios plus random traffic against a
// window-sum reference model; peak expectations follow BQ_PWRMON_PEAK_EN.
module tb_bq_power_monitor;

   localparam int NS   = 8;
   localparam int NB   = 12;
   localparam int WL   = 4;
   localparam int W    = 1 << WL;
   localparam int MAXC = 4096;

   logic aclk = 1'b0;
   logic rst_i;
   always #5 aclk = ~aclk;

   bq_power_monitor_if #(.NSAMP(NS), .NBITS(NB), .WINDOW_LOG2(WL)) bus ();

   bq_power_monitor #(.NSAMP(NS), .NBITS(NB), .WINDOW_LOG2(WL)) dut (
      .aclk  (aclk),
      .rst_i (rst_i),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;

   // Reference model state: per-edge sample statistics and the expected result registers.
   longint st_pow [MAXC];
   int     st_ov  [MAXC];
   int     st_pk  [MAXC];
   int     n = 0;
   int     r = 0;
   bit     active = 0;
   bit     exp_done = 0;
   longint exp_power = 0;
   int     exp_over = 0;
   int     exp_peak = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d (edge %0d)", tag, got, exp, n);
      end
   endtask

   function automatic int pk_exp(input int m);
`ifdef BQ_PWRMON_PEAK_EN
      return m;
`else
      return 0 * m;
`endif
   endfunction

   function automatic logic [NS*NB-1:0] fill(input int v);
      logic [NS*NB-1:0] d;
      for (int i = 0; i < NS; i++) d[NB*i +: NB] = NB'(v);
      return d;
   endfunction

   function automatic logic [NS*NB-1:0] rand_vec();
      logic [NS*NB-1:0] d;
      int mode;
      mode = int'($urandom_range(0, 3));
      for (int i = 0; i < NS; i++) begin
         case (mode)
            0:       d[NB*i +: NB] = NB'($urandom);
            1:       d[NB*i +: NB] = NB'(int'($urandom_range(0, 16)) - 8);
            2:       d[NB*i +: NB] = ($urandom_range(0, 1) == 1) ? NB'(2047) : NB'(-2048);
            default: d[NB*i +: NB] = NB'(int'($urandom_range(0, 300)) - 150);
         endcase
      end
      return d;
   endfunction

   task automatic model_edge(input bit rst, input bit run, input logic [NS*NB-1:0] dat, input int thr);
      longint p;
      int ov, pk, mag, k;
      logic signed [NB-1:0] s;
      exp_done = 0;
      p = 0; ov = 0; pk = 0;
      for (int i = 0; i < NS; i++) begin
         s   = dat[NB*i +: NB];
         mag = (s < 0) ? -int'(s) : int'(s);
         p  += longint'(mag) * longint'(mag);
         if (mag > thr) ov++;
         if (mag > pk) pk = mag;
      end
      st_pow[n] = p; st_ov[n] = ov; st_pk[n] = pk;
      if (rst) begin
         active = 0; exp_power = 0; exp_over = 0; exp_peak = 0;
      end else if (!run) begin
         active = 0;
      end else begin
         if (!active) begin
            active = 1;
            r = n;
         end
         if (n - r >= W + 3 && (n - r - 3) % W == 0) begin
            k = (n - r - 3) / W - 1;
            exp_power = 0; exp_over = 0; pk = 0;
            for (int j = r + k*W; j < r + (k+1)*W; j++) begin
               exp_power += st_pow[j];
               exp_over  += st_ov[j];
               if (st_pk[j] > pk) pk = st_pk[j];
            end
            exp_peak = pk_exp(pk);
            exp_done = 1;
         end
      end
      n++;
   endtask

   task automatic step(input bit rst, input bit run, input logic [NS*NB-1:0] dat, input int thr);
      if (n >= MAXC) begin
         $display("FAIL model_capacity got=%0d exp<%0d", n, MAXC);
         $fatal(1, "model array exhausted");
      end
      rst_i        = rst;
      bus.run_i    = run;
      bus.dat_i    = dat;
      bus.thresh_i = NB'(thr);
      @(posedge aclk);
      model_edge(rst, run, dat, thr);
      #1;
      check_eq("done",  64'(bus.done_o),  64'(exp_done));
      check_eq("power", 64'(bus.power_o), 64'(exp_power));
      check_eq("over",  64'(bus.over_o),  64'(exp_over));
      check_eq("peak",  64'(bus.peak_o),  64'(exp_peak));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dones;
      bit run;
      int thr;
      rst_i = 1'b1; bus.run_i = 1'b0; bus.dat_i = '0; bus.thresh_i = '0;

      repeat (3) step(1, 0, '0, 0);
      check_eq("reset_power", 64'(bus.power_o), 64'd0);
      check_eq("reset_done",  64'(bus.done_o),  64'd0);
      repeat (2) step(0, 0, rand_vec(), 0);

      // Constant positive window: result visible after the 20th run cycle.
      for (int c = 0; c < 20; c++) begin
         step(0, 1, fill(100), 50);
         if (c == 18) check_eq("s1_not_early", 64'(bus.done_o), 64'd0);
      end
      check_eq("s1_done",  64'(bus.done_o),  64'd1);
      check_eq("s1_power", 64'(bus.power_o), 64'd1280000);
      check_eq("s1_over",  64'(bus.over_o),  64'd128);
      check_eq("s1_peak",  64'(bus.peak_o),  64'(pk_exp(100)));
      repeat (3) step(0, 0, fill(100), 50);

      // Negative full scale.
      repeat (20) step(0, 1, fill(-2048), 2047);
      check_eq("nfs_done",  64'(bus.done_o),  64'd1);
      check_eq("nfs_power", 64'(bus.power_o), 64'd536870912);
      check_eq("nfs_over",  64'(bus.over_o),  64'd128);
      check_eq("nfs_peak",  64'(bus.peak_o),  64'(pk_exp(2048)));
      repeat (3) step(0, 0, rand_vec(), 0);

      // Back-to-back windows.
      for (int c = 0; c < 36; c++) begin
         step(0, 1, (c < 16) ? fill(3) : fill(0), 0);
         if (c == 19) begin
            check_eq("b2b_w0_done",  64'(bus.done_o),  64'd1);
            check_eq("b2b_w0_power", 64'(bus.power_o), 64'd1152);
            check_eq("b2b_w0_over",  64'(bus.over_o),  64'd128);
         end
      end
      check_eq("b2b_w1_done",  64'(bus.done_o),  64'd1);
      check_eq("b2b_w1_power", 64'(bus.power_o), 64'd0);
      check_eq("b2b_w1_over",  64'(bus.over_o),  64'd0);
      repeat (3) step(0, 0, rand_vec(), 0);

      // Abort 10 clocks into the second window, then a fresh run.
      for (int c = 0; c < 26; c++) step(0, 1, (c < 16) ? fill(3) : rand_vec(), 0);
      dones = 0;
      repeat (30) begin
         step(0, 0, rand_vec(), 0);
         if (bus.done_o) dones++;
      end
      check_eq("abort_no_done", 64'(dones), 64'd0);
      check_eq("abort_hold",    64'(bus.power_o), 64'd1152);
      for (int c = 0; c < 20; c++) step(0, 1, rand_vec(), int'($urandom_range(0, 2100)));
      check_eq("rerun_done", 64'(bus.done_o), 64'd1);

      // Reset mid-window with run held high.
      repeat (10) step(0, 1, rand_vec(), 100);
      step(1, 1, rand_vec(), 100);
      check_eq("rst_mid_power", 64'(bus.power_o), 64'd0);
      check_eq("rst_mid_over",  64'(bus.over_o),  64'd0);
      check_eq("rst_mid_peak",  64'(bus.peak_o),  64'd0);
      dones = 0;
      for (int c = 0; c < 20; c++) begin
         step(0, 1, rand_vec(), 100);
         if (c < 19 && bus.done_o) dones++;
      end
      check_eq("rst_mid_no_early", 64'(dones), 64'd0);
      check_eq("rst_mid_done",     64'(bus.done_o), 64'd1);

      // Random traffic: run drops, threshold changes, occasional resets.
      run = 1; thr = 500;
      repeat (800) begin
         if ($urandom_range(0, 59) == 0) run = !run;
         if ($urandom_range(0, 7) == 0) thr = int'($urandom_range(0, 2100));
         step(($urandom_range(0, 199) == 0), run, rand_vec(), thr);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bq_power_monitor.md
# bq_power_monitor

Windowed signal-power monitor that sits directly downstream of the two-stage biquad notch chain. It consumes the same NSAMP×12-bit parallel sample bus the chain produces. Per window it reports the sum of squares, the count of samples over a threshold and, optionally, the peak magnitude. Gain-control and diagnostics logic use it to judge filtered-signal level before the trigger beamformer.

## Interface
- NSAMP, 8, samples per clock on the parallel bus
- NBITS, 12, signed two's-complement bits per sample (integer, no fraction)
- WINDOW_LOG2, 10, window length = 2^WINDOW_LOG2 clocks
- aclk  in  1  sample clock; one clock only; every port is synchronous to aclk
- rst_i  in  1  reset, synchronous, active-high
- dat_i  in  NBITS*NSAMP  filtered samples; sample i occupies bits [NBITS*i +: NBITS]
- run_i  in  1  level; high = accumulate back-to-back windows
- thresh_i  in  NBITS  unsigned magnitude threshold
- power_o  out  ACCBITS  sum of squares over the last completed window
- over_o  out  CNTBITS  number of samples with |x| > thresh_i in that window
- peak_o  out  NBITS  max |x| in that window
- done_o  out  1  one-cycle pulse; outputs updated this cycle

## Operation
- ACCBITS = 2*NBITS-1 + clog2(NSAMP) + WINDOW_LOG2. CNTBITS = clog2(NSAMP) + WINDOW_LOG2 + 1.
- Pipeline, one register per stage:
  - S1: register dat_i. Compute |x| as NBITS unsigned, so |-2048| = 2048. Compute per-sample over flags using thresh_i at this cycle.
  - S2: square each sample, 2*NBITS-1 unsigned. Popcount the flags. Take the max of the NSAMP magnitudes.
  - S3: adder-tree sum of squares.
  - S4: accumulate.
- No saturation is required; widths are sized so no overflow is possible.
- State machine:
  - IDLE: accumulators held at 0. run_i=1 → FILL.
  - FILL: 3 cycles of pipeline priming, then → ACCUM.
  - ACCUM: window counter counts 0..2^WINDOW_LOG2-1. On the terminal count the final totals go to the outputs, done_o pulses, and the accumulators reload with the current stage value, so there is no gap between windows. Counter wraps to 0.
- run_i=0 in FILL or ACCUM → IDLE. The partial window is discarded, done_o is not asserted, and outputs hold the last completed window.
- run_i re-asserted starts a fresh window with full FILL.
- Reset at any point: state IDLE, accumulators 0, power_o/over_o/peak_o = 0, done_o = 0. Reset takes precedence over run_i in the same cycle.

## Timing
- run_i first sampled high at edge r. Window k contains dat_i sampled at edges r+kW .. r+(k+1)W-1, with W = 2^WINDOW_LOG2.
- done_o is high in the cycle after edge r+(k+1)W+3, i.e. 4 clocks after the last sample of the window.
- Outputs change only together with done_o and are stable between pulses.
- Window throughput: one result every W clocks while run_i stays high.
- thresh_i is applied per sample at S1. A change mid-window affects only subsequent samples.

## Configuration
- BQ_PWRMON_PEAK_EN
  - Defined: peak tracking logic is built and peak_o reports the window max |x|.
  - Undefined: no peak logic is synthesized and peak_o is constant 0.
  - power_o, over_o and timing are identical in both cases.

## Structure
- Shared package bq_pwrmon_pkg holds:
  - the ACCBITS and CNTBITS width functions;
  - the state enum {IDLE, FILL, ACCUM};
  - the FILL length constant (3).
- One sub-module, bq_pwrmon_sq_tree: S1–S3 (abs, square, adder tree, popcount, max), parameterized by NSAMP and NBITS, with fixed 3-cycle latency.
- The top level holds the FSM, window counter, accumulators and output registers.

## Test plan
All scenarios use WINDOW_LOG2=4 (W=16), NSAMP=8, NBITS=12.
- Constant-positive window: all samples 100, thresh_i=50, run_i rises at r → done_o at r+20 with power_o=1,280,000, over_o=128, peak_o=100.
- Negative full scale: all samples -2048, thresh_i=2047 → power_o=536,870,912 (2^29, no wrap), over_o=128, peak_o=2048.
- Back-to-back windows: first window all samples 3, next window all samples 0 with thresh_i=0 → first done_o reports power_o=1152 and over_o=128; second done_o, exactly 16 clocks later, reports power_o=0 and over_o=0.
- Abort: run_i dropped 10 clocks into the second window → no further done_o, outputs keep first-window values; after re-assert the next done_o comes at 20 clocks.
- Reset mid-window: rst_i pulsed during ACCUM → next cycle all outputs 0, no done_o until a full new window (20 clocks after run_i is next sampled high).
- Macro off: BQ_PWRMON_PEAK_EN undefined with the first scenario's stimulus → peak_o=0, all other results unchanged.
